// File: rtl/udp_sample_framer.sv
// udp_sample_framer: packs 32-bit IQ samples into Ethernet/IPv4/UDP frames
// for a byte-wide MAC transmit write interface. The MAC adds preamble/FCS;
// this block builds the headers, including the IPv4 header checksum.
// Optional: define UDP_FRAMER_SEQNUM_EN to prefix each payload with a
// 4-byte big-endian frame sequence counter.
module udp_sample_framer #(
  parameter int unsigned SAMPLES_PER_PKT = 256,
  parameter int unsigned IP_TTL          = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [47:0] cfg_src_mac,
  input  logic [47:0] cfg_dst_mac,
  input  logic [31:0] cfg_src_ip,
  input  logic [31:0] cfg_dst_ip,
  input  logic [15:0] cfg_src_port,
  input  logic [15:0] cfg_dst_port,
  output logic [7:0]  tx_data,
  output logic        tx_sop,
  output logic        tx_eop,
  output logic        tx_err,
  output logic        tx_wren,
  input  logic        tx_rdy,
  output logic        busy
);

`ifdef UDP_FRAMER_SEQNUM_EN
  localparam int unsigned SEQ_BYTES = 4;
`else
  localparam int unsigned SEQ_BYTES = 0;
`endif
  localparam int unsigned PAY_BYTES = 4 * SAMPLES_PER_PKT + SEQ_BYTES;
  localparam logic [15:0] TOTLEN   = 16'(28 + PAY_BYTES);
  localparam logic [15:0] UDPLEN   = 16'(8 + PAY_BYTES);
  localparam logic [10:0] LAST_PAY = 11'(PAY_BYTES - 1);
  localparam logic [8:0]  N_SAMP   = 9'(SAMPLES_PER_PKT);
  localparam logic [7:0]  TTL      = 8'(IP_TTL);

  typedef enum logic [1:0] {IDLE, CSUM, HEADER, PAYLOAD} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [19:0] acc_q, acc_d;
  logic [15:0] csum_q, csum_d;
  logic [15:0] ident_q, ident_d;
  logic [47:0] src_mac_q, src_mac_d, dst_mac_q, dst_mac_d;
  logic [31:0] src_ip_q, src_ip_d, dst_ip_q, dst_ip_d;
  logic [15:0] src_port_q, src_port_d, dst_port_q, dst_port_d;
  logic [31:0] hold_q, hold_d;
  logic [2:0]  hold_cnt_q, hold_cnt_d;
  logic [8:0]  samp_cnt_q, samp_cnt_d;
  logic [10:0] pay_cnt_q, pay_cnt_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_sop_q, tx_sop_d, tx_eop_q, tx_eop_d, tx_wren_q, tx_wren_d;
  logic        s_ready_q, s_ready_d, busy_q, busy_d;
`ifdef UDP_FRAMER_SEQNUM_EN
  logic [31:0] seq_q, seq_d;
`endif

  logic [335:0] hdr_vec;
  logic [8:0]   hdr_shift;
  logic [7:0]   hdr_byte;
  logic [15:0]  csum_word;
  logic [16:0]  fold1, fold2;
  logic         out_free, take, emit;
  logic [7:0]   emit_byte;

  assign hdr_vec = {dst_mac_q, src_mac_q, 16'h0800, 8'h45, 8'h00, TOTLEN, ident_q,
                    8'h40, 8'h00, TTL, 8'h11, csum_q, src_ip_q, dst_ip_q,
                    src_port_q, dst_port_q, UDPLEN, 16'h0000};
  assign hdr_shift = {6'd41 - cnt_q, 3'b000};
  assign hdr_byte  = hdr_vec[hdr_shift +: 8];

  assign tx_data = tx_data_q;
  assign tx_sop  = tx_sop_q;
  assign tx_eop  = tx_eop_q;
  assign tx_wren = tx_wren_q;
  assign tx_err  = 1'b0;
  assign s_ready = s_ready_q;
  assign busy    = busy_q;

  // Next-state and next-output computation; all outputs are registered below.
  // HEADER hands over to PAYLOAD once byte 41 is loaded into the output
  // register, so the first payload byte can follow it without a gap.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    csum_d     = csum_q;
    ident_d    = ident_q;
    src_mac_d  = src_mac_q;
    dst_mac_d  = dst_mac_q;
    src_ip_d   = src_ip_q;
    dst_ip_d   = dst_ip_q;
    src_port_d = src_port_q;
    dst_port_d = dst_port_q;
    hold_d     = hold_q;
    hold_cnt_d = hold_cnt_q;
    samp_cnt_d = samp_cnt_q;
    pay_cnt_d  = pay_cnt_q;
    tx_data_d  = tx_data_q;
    tx_sop_d   = tx_sop_q;
    tx_eop_d   = tx_eop_q;
    tx_wren_d  = tx_wren_q;
`ifdef UDP_FRAMER_SEQNUM_EN
    seq_d      = seq_q;
`endif
    out_free   = !tx_wren_q || tx_rdy;
    take       = s_ready_q && s_valid;
    emit       = 1'b0;
    emit_byte  = '0;
    fold1      = {1'b0, acc_q[15:0]} + {13'd0, acc_q[19:16]};
    fold2      = {1'b0, fold1[15:0]} + {16'd0, fold1[16]};
    case (cnt_q)
      6'd0:    csum_word = 16'h4500;
      6'd1:    csum_word = TOTLEN;
      6'd2:    csum_word = ident_q;
      6'd3:    csum_word = 16'h4000;
      6'd4:    csum_word = {TTL, 8'h11};
      6'd6:    csum_word = src_ip_q[31:16];
      6'd7:    csum_word = src_ip_q[15:0];
      6'd8:    csum_word = dst_ip_q[31:16];
      6'd9:    csum_word = dst_ip_q[15:0];
      default: csum_word = 16'h0000;
    endcase

    case (state_q)
      IDLE: begin
        if (enable && s_valid) begin
          state_d    = CSUM;
          cnt_d      = '0;
          acc_d      = '0;
          src_mac_d  = cfg_src_mac;
          dst_mac_d  = cfg_dst_mac;
          src_ip_d   = cfg_src_ip;
          dst_ip_d   = cfg_dst_ip;
          src_port_d = cfg_src_port;
          dst_port_d = cfg_dst_port;
        end
      end
      CSUM: begin
        if (cnt_q == 6'd10) begin
          csum_d  = ~fold2[15:0];
          state_d = HEADER;
          cnt_d   = '0;
        end else begin
          acc_d = acc_q + {4'h0, csum_word};
          cnt_d = cnt_q + 6'd1;
        end
      end
      HEADER: begin
        if (out_free) begin
          tx_data_d = hdr_byte;
          tx_sop_d  = (cnt_q == 6'd0);
          tx_eop_d  = 1'b0;
          tx_wren_d = 1'b1;
          if (cnt_q == 6'd41) begin
            state_d    = PAYLOAD;
            pay_cnt_d  = '0;
            samp_cnt_d = '0;
`ifdef UDP_FRAMER_SEQNUM_EN
            hold_d     = seq_q;
            hold_cnt_d = 3'd4;
`else
            hold_cnt_d = 3'd0;
`endif
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      PAYLOAD: begin
        if (tx_wren_q && tx_rdy && tx_eop_q) begin
          state_d   = IDLE;
          tx_wren_d = 1'b0;
          tx_sop_d  = 1'b0;
          tx_eop_d  = 1'b0;
          ident_d   = ident_q + 16'd1;
`ifdef UDP_FRAMER_SEQNUM_EN
          seq_d     = seq_q + 32'd1;
`endif
        end else begin
          // A sample is only taken when the holding register is empty, so
          // it either feeds the output directly or fills the register.
          if (take) begin
            samp_cnt_d = samp_cnt_q + 9'd1;
            if (out_free) begin
              emit       = 1'b1;
              emit_byte  = s_data[31:24];
              hold_d     = {s_data[23:0], 8'h00};
              hold_cnt_d = 3'd3;
            end else begin
              hold_d     = s_data;
              hold_cnt_d = 3'd4;
            end
          end else if (out_free && hold_cnt_q != 3'd0) begin
            emit       = 1'b1;
            emit_byte  = hold_q[31:24];
            hold_d     = {hold_q[23:0], 8'h00};
            hold_cnt_d = hold_cnt_q - 3'd1;
          end
          if (out_free) begin
            tx_sop_d  = 1'b0;
            tx_wren_d = emit;
            tx_eop_d  = emit && (pay_cnt_q == LAST_PAY);
            if (emit) begin
              tx_data_d = emit_byte;
              pay_cnt_d = pay_cnt_q + 11'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    s_ready_d = (state_d == PAYLOAD) && (hold_cnt_d == 3'd0) && (samp_cnt_d < N_SAMP);
    busy_d    = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      csum_q     <= '0;
      ident_q    <= '0;
      src_mac_q  <= '0;
      dst_mac_q  <= '0;
      src_ip_q   <= '0;
      dst_ip_q   <= '0;
      src_port_q <= '0;
      dst_port_q <= '0;
      hold_q     <= '0;
      hold_cnt_q <= '0;
      samp_cnt_q <= '0;
      pay_cnt_q  <= '0;
      tx_data_q  <= '0;
      tx_sop_q   <= 1'b0;
      tx_eop_q   <= 1'b0;
      tx_wren_q  <= 1'b0;
      s_ready_q  <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UDP_FRAMER_SEQNUM_EN
      seq_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      csum_q     <= csum_d;
      ident_q    <= ident_d;
      src_mac_q  <= src_mac_d;
      dst_mac_q  <= dst_mac_d;
      src_ip_q   <= src_ip_d;
      dst_ip_q   <= dst_ip_d;
      src_port_q <= src_port_d;
      dst_port_q <= dst_port_d;
      hold_q     <= hold_d;
      hold_cnt_q <= hold_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      pay_cnt_q  <= pay_cnt_d;
      tx_data_q  <= tx_data_d;
      tx_sop_q   <= tx_sop_d;
      tx_eop_q   <= tx_eop_d;
      tx_wren_q  <= tx_wren_d;
      s_ready_q  <= s_ready_d;
      busy_q     <= busy_d;
`ifdef UDP_FRAMER_SEQNUM_EN
      seq_q      <= seq_d;
`endif
    end
  end

endmodule

// File: tb/tb_udp_sample_framer.sv
// Directed testbench for udp_sample_framer (SAMPLES_PER_PKT=8).
// Expected frames are assembled field by field from the bench's own
// constants; checksums are hand-computed.
module tb_udp_sample_framer;

  localparam int N = 8;
`ifdef UDP_FRAMER_SEQNUM_EN
  localparam int          SEQ    = 4;
  localparam logic [15:0] TOTLEN = 16'h0040;
  localparam logic [15:0] UDPLEN = 16'h002C;
  localparam logic [15:0] CS0    = 16'hB751;
`else
  localparam int          SEQ    = 0;
  localparam logic [15:0] TOTLEN = 16'h003C;
  localparam logic [15:0] UDPLEN = 16'h0028;
  localparam logic [15:0] CS0    = 16'hB755;
`endif
  localparam int FLEN = 42 + 4 * N + SEQ;

  localparam logic [47:0] DST_MAC  = 48'h001122334455;
  localparam logic [47:0] SRC_MAC  = 48'h02AABBCCDDEE;
  localparam logic [31:0] SRC_IP   = 32'hC0A8010A;
  localparam logic [31:0] DST_IP   = 32'hC0A80101;
  localparam logic [15:0] SRC_PORT = 16'h1234;
  localparam logic [15:0] DST_PORT = 16'h5678;

  logic        clk = 1'b0;
  logic        rst, enable, s_valid, s_ready, tx_rdy;
  logic [31:0] s_data;
  logic [7:0]  tx_data;
  logic        tx_sop, tx_eop, tx_err, tx_wren, busy;

  int n_checks = 0;
  int n_errors = 0;
  int k = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  udp_sample_framer #(.SAMPLES_PER_PKT(8), .IP_TTL(64)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .cfg_src_mac(SRC_MAC), .cfg_dst_mac(DST_MAC),
    .cfg_src_ip(SRC_IP), .cfg_dst_ip(DST_IP),
    .cfg_src_port(SRC_PORT), .cfg_dst_port(DST_PORT),
    .tx_data(tx_data), .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_err(tx_err),
    .tx_wren(tx_wren), .tx_rdy(tx_rdy), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sample_val(input int i);
    logic [7:0] b;
    b = 8'(i);
    if (i == 0) return 32'h11223344;
    if (i == 1) return 32'h55667788;
    return {b, b + 8'h40, ~b, b ^ 8'hA5};
  endfunction

  task automatic push_be(input logic [63:0] v, input int nbytes);
    for (int i = nbytes - 1; i >= 0; i--) exp_q.push_back(v[i*8 +: 8]);
  endtask

  task automatic build_exp(input logic [15:0] ident, input logic [15:0] csum,
                           input logic [31:0] seq, input int base);
    exp_q.delete();
    push_be(64'(DST_MAC), 6);
    push_be(64'(SRC_MAC), 6);
    push_be(64'h0800, 2);
    push_be(64'h4500, 2);
    push_be(64'(TOTLEN), 2);
    push_be(64'(ident), 2);
    push_be(64'h4000, 2);
    push_be(64'h4011, 2);
    push_be(64'(csum), 2);
    push_be(64'(SRC_IP), 4);
    push_be(64'(DST_IP), 4);
    push_be(64'(SRC_PORT), 2);
    push_be(64'(DST_PORT), 2);
    push_be(64'(UDPLEN), 2);
    push_be(64'h0000, 2);
    if (SEQ != 0) push_be(64'(seq), 4);
    for (int s = 0; s < N; s++) push_be(64'(sample_val(base + s)), 4);
  endtask

  // mode 0: tx_rdy=1; mode 1: fixed stall pattern on tx_rdy; mode 2: 5-cycle s_valid gap.
  task automatic run_frame(input string name, input int mode, input logic [15:0] ident,
                           input logic [15:0] csum, input logic [31:0] seq, input int base,
                           input int abort_at, input bit drop_en);
    int n, gaps, gap_left;
    bit gap_done, done, aborted, prev_stall;
    logic [10:0] prev_out;
    logic [15:0] pat;
    n = 0; gaps = 0; gap_left = 0;
    gap_done = 0; done = 0; aborted = 0; prev_stall = 0;
    prev_out = '0;
    pat = 16'b1011_0011_1000_1101;
    build_exp(ident, csum, seq, base);
    for (int cyc = 0; cyc < 3000 && !done && !aborted; cyc++) begin
      @(negedge clk);
      if (prev_stall)
        check({name, "_hold"}, {21'b0, tx_wren, tx_sop, tx_eop, tx_data}, {21'b0, prev_out});
      tx_rdy  = (mode == 1) ? pat[cyc % 16] : 1'b1;
      s_valid = 1'b1;
      if (mode == 2 && !gap_done && n >= 54 && s_ready) begin
        gap_left = 5;
        gap_done = 1;
      end
      if (gap_left > 0) begin
        s_valid = 1'b0;
        gap_left--;
      end
      s_data = sample_val(k);
      if (drop_en && n >= 1) enable = 1'b0;
      if (abort_at >= 0 && n == abort_at) begin
        rst = 1'b1;
        aborted = 1;
      end else begin
        if (s_valid && s_ready) k++;
        if (tx_wren && tx_rdy) begin
          if (n < exp_q.size()) check($sformatf("%s_byte%0d", name, n), 32'(tx_data), 32'(exp_q[n]));
          else check({name, "_overrun"}, 32'(n), 32'(FLEN - 1));
          check($sformatf("%s_sop%0d", name, n), 32'(tx_sop), 32'(n == 0));
          check($sformatf("%s_eop%0d", name, n), 32'(tx_eop), 32'(n == FLEN - 1));
          n++;
          if (tx_eop) done = 1;
        end else if (!tx_wren && n > 0) begin
          gaps++;
        end
      end
      prev_stall = tx_wren && !tx_rdy;
      prev_out   = {tx_wren, tx_sop, tx_eop, tx_data};
    end
    if (abort_at >= 0) begin
      check({name, "_abort_reached"}, 32'(aborted), 32'd1);
    end else begin
      check({name, "_completed"}, 32'(done), 32'd1);
      check({name, "_len"}, 32'(n), 32'(FLEN));
      check({name, "_gaps"}, 32'(gaps), (mode == 2) ? 32'd5 : 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0; tx_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wren", 32'(tx_wren), 32'd0);
    check("rst_sop", 32'(tx_sop), 32'd0);
    check("rst_eop", 32'(tx_eop), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(tx_err), 32'd0);
    rst = 1'b0;
    enable = 1'b1;

    run_frame("f0", 0, 16'h0000, CS0,          32'd0, 0,  -1, 0);
    run_frame("f1", 1, 16'h0001, CS0 - 16'd1,  32'd1, 8,  -1, 0);
    run_frame("f2", 2, 16'h0002, CS0 - 16'd2,  32'd2, 16, -1, 0);
    run_frame("f3", 0, 16'h0003, CS0 - 16'd3,  32'd3, 24, 20, 0);

    @(negedge clk);
    check("abort_wren", 32'(tx_wren), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_s_ready", 32'(s_ready), 32'd0);
    rst = 1'b0;

    run_frame("f4", 0, 16'h0000, CS0, 32'd0, 24, -1, 1);

    repeat (30) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_wren", 32'(tx_wren), 32'd0);
    check("idle_s_ready", 32'(s_ready), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/udp_sample_framer.md
Name: udp_sample_framer

Overview:
Packs the continuous 32-bit IQ sample stream into Ethernet/IPv4/UDP frames for the MII transmit MAC. Frames have a fixed payload size. The block emits frame bytes with start/end-of-packet markers on the MAC's byte-wide transmit write interface. The MAC appends the preamble and FCS; this block generates the headers, including the IPv4 header checksum.

Parameters:
SAMPLES_PER_PKT, 256, IQ samples per frame; legal range 5..360 (payload of 20..1440 bytes).
IP_TTL, 64, IPv4 time-to-live field.

Ports:
clk  in  1  single clock; same clock as the MAC tx_clk.
rst  in  1  synchronous, active-high reset; assert together with the MAC reset.
enable  in  1  1 = start new frames; 0 = finish the current frame, then idle.
s_data  in  32  sample, {I[15:0], Q[15:0]}.
s_valid  in  1  s_data is valid.
s_ready  out  1  sample is accepted on s_valid & s_ready.
cfg_src_mac  in  48  sampled on leaving IDLE.
cfg_dst_mac  in  48  sampled on leaving IDLE.
cfg_src_ip  in  32  sampled on leaving IDLE.
cfg_dst_ip  in  32  sampled on leaving IDLE.
cfg_src_port  in  16  sampled on leaving IDLE.
cfg_dst_port  in  16  sampled on leaving IDLE.
tx_data  out  8  frame byte.
tx_sop  out  1  first byte of the frame.
tx_eop  out  1  last byte of the frame.
tx_err  out  1  constant 0.
tx_wren  out  1  byte is offered.
tx_rdy  in  1  MAC can accept a byte; a byte transfers on tx_wren & tx_rdy.
busy  out  1  state != IDLE.

Behaviour:
- Reset: state IDLE; tx_wren, tx_sop, tx_eop, tx_data, s_ready and busy are all 0; ident counter = 0; seq counter = 0.
- All outputs are registered.
- Handshake:
  - tx_data/sop/eop are held stable while tx_wren=1 and tx_rdy=0.
  - The next byte appears on the cycle after a transfer.
  - One byte per cycle is sustainable while tx_rdy=1.
- Lengths: P = 4*SAMPLES_PER_PKT (+4 with the optional feature). IP total length = 28+P. UDP length = 8+P.
- FSM states:
  - IDLE -> CSUM when enable & s_valid. Latch all cfg_* inputs and the ident counter.
  - CSUM: 16-bit one's-complement sum over ten words, one word per cycle, in this order: 0x4500, totlen, ident, 0x4000, {IP_TTL, 0x11}, 0x0000, src_ip hi, src_ip lo, dst_ip hi, dst_ip lo. Carries are accumulated in a 20-bit register. An 11th cycle folds end-around carries twice and inverts; the result is the checksum. Then go to HEADER.
  - HEADER: 42 bytes, big-endian, in this order:
    - dst_mac, src_mac, 0x0800;
    - 0x45, 0x00, totlen, ident, 0x40, 0x00, IP_TTL, 0x11, checksum, src_ip, dst_ip;
    - src_port, dst_port, udplen, 0x0000 (UDP checksum disabled).
    - tx_sop=1 on byte 0 only.
    - After byte 41 transfers, go to PAYLOAD.
  - PAYLOAD:
    - s_ready=1 only while the 32-bit holding register is empty.
    - An accepted sample is emitted as I[15:8], I[7:0], Q[15:8], Q[7:0].
    - If no sample is available, tx_wren=0 (gap) and the frame continues; no timeout.
    - tx_eop=1 on payload byte P-1.
    - When eop transfers, ident++ (wraps 0xFFFF->0), then go to IDLE.
- The first sample is not consumed in IDLE/CSUM; s_valid only triggers frame start.
- enable dropping mid-frame has no effect until the frame ends.
- cfg_* changes mid-frame have no effect until the next frame.
- s_ready is 0 outside PAYLOAD.
- rst mid-frame: immediate return to reset values; the partial frame is abandoned. The MAC reset, applied together, flushes it.

Optional Feature:
UDP_FRAMER_SEQNUM_EN:
- Defined: a 4-byte big-endian frame sequence counter is inserted as the first 4 payload bytes, before the samples. P includes these 4 bytes. The counter increments per completed frame and wraps at 2^32.
- Undefined: the payload contains samples only; there is no counter logic.

Test Plan:
- SAMPLES_PER_PKT=8, feature off, src_ip 192.168.1.10, dst_ip 192.168.1.1, tx_rdy=1, s_valid=1 -> 74-byte frame; sop on byte 0; eop on byte 73; totlen 0x003C; ident 0x0000; checksum 0xB755; udplen 0x0028.
- Send samples 0x11223344, 0x55667788 -> payload starts 11 22 33 44 55 66 77 88; no gaps with s_valid held high.
- tx_rdy toggled pseudo-randomly during HEADER/PAYLOAD -> byte sequence identical to the tx_rdy=1 case; no byte duplicated or dropped; data held while stalled.
- Three back-to-back frames -> ident 0, 1, 2 with checksums recomputed accordingly. With the feature on, sequence bytes are 00000000, 00000001, 00000002 and totlen is 0x0040.
- s_valid deasserted for 5 cycles mid-payload -> tx_wren low for those cycles; frame length unchanged; eop still lands on payload byte P-1.
- rst asserted at header byte 20 -> next cycle tx_wren=0, busy=0. The next frame starts from byte 0 with ident 0.
